// File: rtl/mem_sram_arbiter.sv
// mem_sram_arbiter
//   Shares one single-port SRAM between two requesters: instruction fetch
//   (imem, port 0) and load/store (dmem, port 1). Round-robin arbitration,
//   at most one SRAM access in flight, one access per cycle when the owner
//   acks its response in the same cycle it appears. A response the owner
//   does not accept is held in a buffer until it is acked.
//
// Ports
//   g_clk, g_reset            clock, asynchronous active-high reset
//   {imem,dmem}_req/gnt       request channel; gnt in the same cycle as cen
//   {imem,dmem}_wen/strb/addr/wdata  request payload, stable until gnt
//   {imem,dmem}_recv/ack      response channel; recv held until ack
//   {imem,dmem}_rdata/error   response payload (rdata = 0 for writes)
//   sram_cen/wstrb/addr/wdata SRAM command, driven combinationally from winner
//   sram_rdata/sram_err       SRAM result, valid the cycle after cen
module mem_sram_arbiter #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic                 g_clk,
  input  logic                 g_reset,

  input  logic                 imem_req,
  output logic                 imem_gnt,
  input  logic                 imem_wen,
  input  logic [WIDTH/8-1:0]   imem_strb,
  input  logic [ADDR_W-1:0]    imem_addr,
  input  logic [WIDTH-1:0]     imem_wdata,
  output logic                 imem_recv,
  input  logic                 imem_ack,
  output logic [WIDTH-1:0]     imem_rdata,
  output logic                 imem_error,

  input  logic                 dmem_req,
  output logic                 dmem_gnt,
  input  logic                 dmem_wen,
  input  logic [WIDTH/8-1:0]   dmem_strb,
  input  logic [ADDR_W-1:0]    dmem_addr,
  input  logic [WIDTH-1:0]     dmem_wdata,
  output logic                 dmem_recv,
  input  logic                 dmem_ack,
  output logic [WIDTH-1:0]     dmem_rdata,
  output logic                 dmem_error,

  output logic                 sram_cen,
  output logic [WIDTH/8-1:0]   sram_wstrb,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [WIDTH-1:0]     sram_wdata,
  input  logic [WIDTH-1:0]     sram_rdata,
  input  logic                 sram_err
);

  localparam int SW = WIDTH / 8;

  typedef struct packed {
    logic              wen;
    logic [SW-1:0]     strb;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing in flight
    RESP = 2'd1,  // access issued last cycle, SRAM outputs valid now
    HOLD = 2'd2   // response buffered, waiting for ack
  } state_t;

  state_t           state;
  logic             owner;      // 0 = imem, 1 = dmem
  logic             last;       // port granted most recently
  logic             wen_q;      // in-flight access is a write
  logic [WIDTH-1:0] buf_rdata;
  logic             buf_err;

  logic [1:0] req;
  logic [1:0] ack;
  logic       owner_ack;
  logic       free;
  logic       winner;
  logic       grant_any;
  req_t       imem_r, dmem_r, win_r;

  logic             resp_vld;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  assign req    = {dmem_req, imem_req};
  assign ack    = {dmem_ack, imem_ack};
  assign imem_r = '{wen: imem_wen, strb: imem_strb, addr: imem_addr, wdata: imem_wdata};
  assign dmem_r = '{wen: dmem_wen, strb: dmem_strb, addr: dmem_addr, wdata: dmem_wdata};

  // The owner's ack retires the current response, so a new access may be
  // issued in that same cycle; this is what gives back-to-back throughput.
  assign owner_ack = ack[owner];
  assign free      = (state == IDLE) |
                     (((state == RESP) | (state == HOLD)) & owner_ack);

  // Under contention the port not granted last time wins.
  assign winner    = (req[0] & req[1]) ? ~last : req[1];
  assign grant_any = free & (|req) & ~g_reset;
  assign win_r     = winner ? dmem_r : imem_r;

  assign imem_gnt = grant_any & ~winner;
  assign dmem_gnt = grant_any &  winner;

  // Idle SRAM command is all zero; zero wstrb on reads keeps a ROM's
  // write-error flag low.
  assign sram_cen   = grant_any;
  assign sram_addr  = grant_any ? win_r.addr  : '0;
  assign sram_wdata = grant_any ? win_r.wdata : '0;
  assign sram_wstrb = (grant_any & win_r.wen) ? win_r.strb : '0;

  // Response comes straight from the SRAM in RESP, from the buffer in HOLD.
  assign resp_vld   = (state == RESP) | (state == HOLD);
  assign resp_rdata = (state == RESP) ? (wen_q ? '0 : sram_rdata) : buf_rdata;
  assign resp_err   = (state == RESP) ? sram_err : buf_err;

  assign imem_recv  = resp_vld & ~owner;
  assign dmem_recv  = resp_vld &  owner;
  assign imem_rdata = imem_recv ? resp_rdata : '0;
  assign dmem_rdata = dmem_recv ? resp_rdata : '0;
  assign imem_error = imem_recv & resp_err;
  assign dmem_error = dmem_recv & resp_err;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      wen_q     <= 1'b0;
      buf_rdata <= '0;
      buf_err   <= 1'b0;
    end else if (grant_any) begin
      // A grant implies the previous response (if any) was acked this cycle.
      state <= RESP;
      owner <= winner;
      last  <= winner;
      wen_q <= win_r.wen;
    end else begin
      case (state)
        RESP: begin
          if (owner_ack) begin
            state <= IDLE;
          end else begin
            // SRAM outputs are only valid this cycle; keep them for the owner.
            buf_rdata <= resp_rdata;
            buf_err   <= sram_err;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (owner_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_arbiter.sv
module tb_mem_sram_arbiter;

  localparam int WIDTH  = 64;
  localparam int ADDR_W = 32;

  logic              g_clk;
  logic              g_reset;
  logic              imem_req, imem_gnt, imem_wen, imem_recv, imem_ack, imem_error;
  logic [7:0]        imem_strb;
  logic [ADDR_W-1:0] imem_addr;
  logic [WIDTH-1:0]  imem_wdata, imem_rdata;
  logic              dmem_req, dmem_gnt, dmem_wen, dmem_recv, dmem_ack, dmem_error;
  logic [7:0]        dmem_strb;
  logic [ADDR_W-1:0] dmem_addr;
  logic [WIDTH-1:0]  dmem_wdata, dmem_rdata;
  logic              sram_cen;
  logic [7:0]        sram_wstrb;
  logic [ADDR_W-1:0] sram_addr;
  logic [WIDTH-1:0]  sram_wdata;
  logic [WIDTH-1:0]  sram_rdata;
  logic              sram_err;
  logic              rom;

  int n_cmp = 0;
  int n_err = 0;

  mem_sram_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_wen(imem_wen),
    .imem_strb(imem_strb), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_error(imem_error),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error),
    .sram_cen(sram_cen), .sram_wstrb(sram_wstrb), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_err(sram_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Word i of both memories starts as 0x0101..01 * i, except word 8 (0x40).
  function automatic logic [63:0] init_word(input int i);
    if (i == 8) return 64'h1122334455667788;
    return 64'h0101010101010101 * 64'(i);
  endfunction

  // ---------------- SRAM model (RAM, or ROM when rom=1) ----------------
  logic [63:0] smem [0:127];
  bit          s_init = 0;
  always @(posedge g_clk) begin
    if (!s_init) begin
      for (int i = 0; i < 128; i++) smem[i] <= init_word(i);
      s_init <= 1;
    end else if (sram_cen) begin
      sram_rdata <= smem[sram_addr[9:3]];
      if (!rom)
        for (int b = 0; b < 8; b++)
          if (sram_wstrb[b]) smem[sram_addr[9:3]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
    sram_err <= sram_cen && rom && (sram_wstrb != 8'h00);
  end

  // ---------------- transaction-level reference model ----------------
  // One outstanding response record; expected data is taken from a shadow
  // memory at grant time.
  logic [63:0] shadow [0:127];
  bit          m_init = 0;
  bit          m_pv = 0;     // response pending
  bit          m_pp = 0;     // port it belongs to
  logic [63:0] m_pd = '0;
  bit          m_pe = 0;
  bit          m_last = 1;   // port granted last

  always @(negedge g_clk) begin
    bit          mfree, w, g, wen;
    logic [7:0]  strb, e_wstrb;
    logic [31:0] addr, e_addr;
    logic [63:0] wd, e_wdata, word;
    if (!m_init) begin
      for (int i = 0; i < 128; i++) shadow[i] = init_word(i);
      m_init = 1;
    end
    mfree = !m_pv || (m_pp ? dmem_ack : imem_ack);
    g     = !g_reset && mfree && (imem_req || dmem_req);
    w     = (imem_req && dmem_req) ? !m_last : dmem_req;
    wen   = w ? dmem_wen : imem_wen;
    strb  = w ? dmem_strb : imem_strb;
    addr  = w ? dmem_addr : imem_addr;
    wd    = w ? dmem_wdata : imem_wdata;
    e_addr  = g ? addr : '0;
    e_wdata = g ? wd : '0;
    e_wstrb = (g && wen) ? strb : '0;

    chk("imem_gnt", imem_gnt, g && !w);
    chk("dmem_gnt", dmem_gnt, g && w);
    chk("sram_cen", sram_cen, g);
    chk("sram_addr", sram_addr, e_addr);
    chk("sram_wdata", sram_wdata, e_wdata);
    chk("sram_wstrb", sram_wstrb, e_wstrb);
    chk("imem_recv", imem_recv, !g_reset && m_pv && !m_pp);
    chk("dmem_recv", dmem_recv, !g_reset && m_pv && m_pp);
    chk("imem_rdata", imem_rdata, (!g_reset && m_pv && !m_pp) ? m_pd : 64'h0);
    chk("dmem_rdata", dmem_rdata, (!g_reset && m_pv && m_pp) ? m_pd : 64'h0);
    chk("imem_error", imem_error, !g_reset && m_pv && !m_pp && m_pe);
    chk("dmem_error", dmem_error, !g_reset && m_pv && m_pp && m_pe);

    if (g_reset) begin
      m_pv = 0;
      m_last = 1;
    end else begin
      if (m_pv && mfree) m_pv = 0;
      if (g) begin
        m_pv = 1;
        m_pp = w;
        m_last = w;
        if (wen) begin
          m_pd = '0;
          m_pe = rom;
          if (!rom) begin
            word = shadow[addr[9:3]];
            for (int b = 0; b < 8; b++)
              if (strb[b]) word[8*b +: 8] = wd[8*b +: 8];
            shadow[addr[9:3]] = word;
          end
        end else begin
          m_pd = shadow[addr[9:3]];
          m_pe = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    g_reset = 1; rom = 0;
    imem_req = 1; imem_wen = 0; imem_strb = '0; imem_addr = '0; imem_wdata = '0; imem_ack = 0;
    dmem_req = 1; dmem_wen = 0; dmem_strb = '0; dmem_addr = '0; dmem_wdata = '0; dmem_ack = 0;
    #3;
    chk("rst_imem_gnt", imem_gnt, 0);
    chk("rst_dmem_gnt", dmem_gnt, 0);
    chk("rst_cen", sram_cen, 0);
    chk("rst_imem_recv", imem_recv, 0);
    chk("rst_dmem_recv", dmem_recv, 0);
    cyc(); cyc();
    g_reset = 0; imem_req = 0; dmem_req = 0; imem_ack = 1; dmem_ack = 1;
    cyc();

    // single read
    imem_req = 1; imem_addr = 32'h40;
    #2;
    chk("rd_gnt", imem_gnt, 1);
    chk("rd_cen", sram_cen, 1);
    chk("rd_addr", sram_addr, 64'h40);
    cyc();
    imem_req = 0;
    #2;
    chk("rd_recv", imem_recv, 1);
    chk("rd_rdata", imem_rdata, 64'h1122334455667788);
    chk("rd_dmem_recv", dmem_recv, 0);
    cyc();

    // contention straight out of reset
    g_reset = 1; imem_addr = 32'h80; dmem_addr = 32'h100; imem_req = 1; dmem_req = 1;
    cyc();
    g_reset = 0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("ct_imem_gnt", imem_gnt, (k % 2) == 0);
      chk("ct_dmem_gnt", dmem_gnt, (k % 2) == 1);
      chk("ct_addr", sram_addr, (k % 2) == 0 ? 64'h80 : 64'h100);
      if (k > 0) begin
        chk("ct_imem_recv", imem_recv, (k % 2) == 1);
        chk("ct_dmem_recv", dmem_recv, (k % 2) == 0);
      end
      cyc();
    end
    imem_req = 0; dmem_req = 0;
    #2;
    chk("ct_last_recv", dmem_recv, 1);
    chk("ct_last_rdata", dmem_rdata, 64'h2020202020202020);
    cyc();

    // backpressure: dmem holds off ack while imem waits
    dmem_req = 1; dmem_addr = 32'h48; dmem_ack = 0;
    #2;
    chk("bp_dmem_gnt", dmem_gnt, 1);
    cyc();
    dmem_req = 0; imem_req = 1; imem_addr = 32'h40;
    for (int j = 0; j < 3; j++) begin
      #2;
      chk("bp_recv", dmem_recv, 1);
      chk("bp_rdata", dmem_rdata, 64'h0909090909090909);
      chk("bp_imem_gnt", imem_gnt, 0);
      cyc();
    end
    dmem_ack = 1;
    #2;
    chk("bp_release_gnt", imem_gnt, 1);
    chk("bp_release_recv", dmem_recv, 1);
    cyc();
    imem_req = 0;
    #2;
    chk("bp_imem_rdata", imem_rdata, 64'h1122334455667788);
    cyc();

    // partial write then read-back
    dmem_req = 1; dmem_wen = 1; dmem_strb = 8'h0F; dmem_addr = 32'h50;
    dmem_wdata = 64'hAAAAAAAABBBBBBBB;
    #2;
    chk("wr_wstrb", sram_wstrb, 64'h0F);
    chk("wr_gnt", dmem_gnt, 1);
    cyc();
    dmem_req = 0; dmem_wen = 0; dmem_strb = '0;
    #2;
    chk("wr_recv", dmem_recv, 1);
    chk("wr_rdata", dmem_rdata, 0);
    chk("wr_error", dmem_error, 0);
    cyc();
    dmem_req = 1;
    #2;
    chk("rb_wstrb", sram_wstrb, 0);
    cyc();
    dmem_req = 0;
    #2;
    chk("rb_rdata", dmem_rdata, 64'h0A0A0A0ABBBBBBBB);
    cyc();

    // ROM: write errors, read does not
    rom = 1;
    dmem_req = 1; dmem_wen = 1; dmem_strb = 8'hFF; dmem_addr = 32'h58;
    cyc();
    dmem_req = 0; dmem_wen = 0; dmem_strb = '0;
    #2;
    chk("rom_wr_recv", dmem_recv, 1);
    chk("rom_wr_error", dmem_error, 1);
    cyc();
    dmem_req = 1;
    cyc();
    dmem_req = 0;
    #2;
    chk("rom_rd_error", dmem_error, 0);
    chk("rom_rd_rdata", dmem_rdata, 64'h0B0B0B0B0B0B0B0B);
    cyc();
    rom = 0;

    // reset during RESP
    imem_req = 1; imem_addr = 32'h40; imem_ack = 0;
    cyc();
    dmem_req = 1; dmem_addr = 32'h48; g_reset = 1;
    #2;
    chk("mr_imem_recv", imem_recv, 0);
    chk("mr_imem_gnt", imem_gnt, 0);
    chk("mr_dmem_gnt", dmem_gnt, 0);
    chk("mr_cen", sram_cen, 0);
    cyc();
    g_reset = 0; imem_ack = 1;
    #2;
    chk("mr_first_gnt", imem_gnt, 1);
    chk("mr_first_dgnt", dmem_gnt, 0);
    chk("mr_no_stale_recv", imem_recv, 0);
    cyc();
    imem_req = 0;
    cyc();
    dmem_req = 0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_sram_arbiter.md
Name: mem_sram_arbiter

Overview:
- Shares one single-port mem_sram_wxd instance between two requesters: instruction fetch (imem) and load/store (dmem).
- Uses the codebase req/gnt request channel and recv/ack response channel.
- Round-robin arbitration, at most one SRAM access in flight, back-to-back throughput of one access per cycle.
- Buffers a response the requester has not yet accepted.

Parameters:
- WIDTH, 64, SRAM word width in bits; must be a multiple of 8.
- ADDR_W, 32, width of the address passed through to the SRAM.

Ports:
- g_clk  input  1  clock.
- g_reset  input  1  asynchronous, active-high reset.
- imem_req / dmem_req  input  1  request valid.
- imem_gnt / dmem_gnt  output  1  request accepted this cycle.
- imem_wen / dmem_wen  input  1  1 = write, 0 = read.
- imem_strb / dmem_strb  input  WIDTH/8  byte write strobes.
- imem_addr / dmem_addr  input  ADDR_W  byte address.
- imem_wdata / dmem_wdata  input  WIDTH  write data.
- imem_recv / dmem_recv  output  1  response valid.
- imem_ack / dmem_ack  input  1  response accepted.
- imem_rdata / dmem_rdata  output  WIDTH  read data.
- imem_error / dmem_error  output  1  access error.
- sram_cen  output  1  SRAM access enable.
- sram_wstrb  output  WIDTH/8  SRAM write strobes.
- sram_addr  output  ADDR_W  SRAM address.
- sram_wdata  output  WIDTH  SRAM write data.
- sram_rdata  input  WIDTH  SRAM read data, valid the cycle after cen.
- sram_err  input  1  SRAM error, valid the cycle after cen.

Behaviour:
- FSM states:
  - IDLE: nothing in flight.
  - RESP: access issued last cycle; SRAM outputs are valid now.
  - HOLD: response buffered, waiting for ack.
- owner: registered bit naming the port that holds the in-flight transaction.
- free = (state==IDLE) | ((state==RESP | state==HOLD) & owner_ack), where owner_ack is the ack input of the owner port.
- Grant (combinational):
  - If free and exactly one req is high, that port gets gnt.
  - If free and both reqs are high, gnt goes to the port not granted last time (register last).
  - Reset value of last = dmem, so the first contention goes to imem.
  - gnt is never asserted while g_reset is high or when not free.
- Request rules: req and its payload must stay stable until gnt. gnt is asserted in the same cycle as cen.
- SRAM drive (combinational, from the granted port):
  - sram_cen = any gnt.
  - sram_addr and sram_wdata come from the winner.
  - sram_wstrb = winner_wen ? winner_strb : 0.
  - With no grant, cen = 0, wstrb = 0, and addr/wdata = 0. The zero wstrb keeps a ROM-variant sram_err low.
- On grant: owner <= winner, wen_q <= winner_wen, last <= winner, next state = RESP.
- In RESP:
  - owner_recv = 1.
  - owner_rdata = wen_q ? 0 : sram_rdata.
  - owner_error = sram_err.
  - If owner_ack: next state = RESP if a new grant occurs this cycle, else IDLE.
  - If no ack: capture rdata/error into buffer, next state = HOLD.
- In HOLD:
  - owner_recv = 1, driven from the buffer.
  - On owner_ack: next state = RESP on a new grant, else IDLE.
- Non-owner recv, rdata and error are always 0. ack while recv is low is ignored.
- Latency: read data is returned the cycle after gnt. Sustained back-to-back rate is 1 access per cycle when ack is held high.
- Writes also produce a response: rdata = 0, error = sram_err.
- Reset (asynchronous, also mid-transaction):
  - state = IDLE, owner = imem, last = dmem, wen_q = 0, buffer = 0.
  - All recv, gnt, error and rdata outputs = 0; sram_cen = 0.
  - An in-flight response is dropped; no recv follows reset release.

Test Plan:
- Single read: imem_req with addr 0x40, SRAM word = 0x1122334455667788 -> imem_gnt = 1 and sram_cen = 1 in cycle 0; imem_recv = 1 with rdata 0x1122334455667788 in cycle 1; dmem_recv = 0 throughout.
- Contention: both req high from reset release -> gnt order imem, dmem, imem, dmem on consecutive cycles with ack tied high. sram_addr alternates accordingly, and each recv arrives 1 cycle after its gnt.
- Backpressure: dmem read, dmem_ack low for 3 cycles while imem_req is high -> dmem_recv stays 1 with stable rdata through HOLD and no gnt to imem. imem_gnt is asserted in the same cycle dmem_ack rises.
- Write: dmem_wen = 1, strb = 0x0F, wdata = 0xAAAAAAAA_BBBBBBBB -> sram_wstrb = 0x0F in the grant cycle; dmem_recv next cycle with rdata 0. A later read of the same address returns the upper 4 bytes unchanged and the lower bytes = 0xBBBBBBBB.
- ROM error: write to a ROM SRAM -> error = 1 with recv. A following read -> error = 0 (wstrb is 0 for reads).
- Reset mid-op: assert g_reset in the RESP cycle -> all recv/gnt/sram_cen drop to 0 immediately. After release, the first contention is granted to imem.
